dff_resp_checker: RTL and testbench

//  Synthesizable self-checking receiver for the D flip-flop variants: samples the stimulus
//  the bench drives into the flops and the three outputs the flops return.

---
 rtl/dff_chk_pkg.sv | 15 +
 rtl/dff_ref_model.sv | 34 +++
 rtl/dff_resp_checker.sv | 125 ++++++++++++
 tb/tb_dff_resp_checker.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dff_chk_pkg.sv
// Shared types and bit indices for the D flip-flop response checker.
package dff_chk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WARM  = 2'd1,
        CHECK = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam int IDX_NORST = 0;
    localparam int IDX_SYNC  = 1;
    localparam int IDX_ASYNC = 2;

endpackage

// File: rtl/dff_ref_model.sv
// Golden model of the three flop variants: one-deep d/dut_rst history plus
// the expected-output equations. The async term also looks at the current
// dut_rst sample because an async flop clears as soon as reset rises.
module dff_ref_model #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dut_rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] exp_norst_o,
    output logic [WIDTH-1:0] exp_sync_o,
    output logic [WIDTH-1:0] exp_async_o
);

    logic [WIDTH-1:0] r_d_prev;
    logic             r_rst_prev;

    // capture one cycle of stimulus history; cleared by checker reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_d_prev   <= '0;
            r_rst_prev <= 1'b0;
        end else begin
            r_d_prev   <= d_i;
            r_rst_prev <= dut_rst_i;
        end
    end

    assign exp_norst_o = r_d_prev;
    assign exp_sync_o  = r_rst_prev ? '0 : r_d_prev;
    assign exp_async_o = (dut_rst_i | r_rst_prev) ? '0 : r_d_prev;

endmodule

// File: rtl/dff_resp_checker.sv
// Self-checking receiver for the D flip-flop variants: compares the returned
// flop outputs against dff_ref_model and keeps saturating check/error counts.
//
//  state | meaning
//  IDLE  | outputs hold; en_i=1 arms (clears counters) and goes to WARM
//  WARM  | one cycle to fill the stimulus history, no compare
//  CHECK | compare every cycle; halt when err count hits MAX_ERR or saturates
//  HALT  | counters frozen until en_i drops
module dff_resp_checker
    import dff_chk_pkg::*;
#(
    parameter int WIDTH   = 1,
    parameter int CNT_W   = 16,
    parameter int MAX_ERR = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             dut_rst_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic [WIDTH-1:0] q_norst_i,
    input  logic [WIDTH-1:0] q_syncrst_i,
    input  logic [WIDTH-1:0] q_asyncrst_i,
    output logic             err_o,
    output logic [2:0]       first_err_vec_o,
    output logic [CNT_W-1:0] first_err_cycle_o,
    output logic [CNT_W-1:0] chk_cnt_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic             halted_o
);

    state_t           r_state;
    logic             r_err_flag;
    logic [2:0]       r_first_vec;
    logic [CNT_W-1:0] r_first_cyc;
    logic [CNT_W-1:0] r_chk_cnt;
    logic [CNT_W-1:0] r_err_cnt;

    logic [WIDTH-1:0] w_exp_norst;
    logic [WIDTH-1:0] w_exp_sync;
    logic [WIDTH-1:0] w_exp_async;
    logic [2:0]       w_mis;
    logic [CNT_W-1:0] w_chk_next;
    logic [CNT_W-1:0] w_err_next;
    logic             w_halt_hit;

    dff_ref_model #(.WIDTH(WIDTH)) u_ref (
        .clk         (clk),
        .rst         (rst),
        .dut_rst_i   (dut_rst_i),
        .d_i         (d_i),
        .exp_norst_o (w_exp_norst),
        .exp_sync_o  (w_exp_sync),
        .exp_async_o (w_exp_async)
    );

    // case-inequality so X/Z on a returned output counts as a mismatch
    assign w_mis[IDX_NORST] = (q_norst_i    !== w_exp_norst);
    assign w_mis[IDX_SYNC]  = (q_syncrst_i  !== w_exp_sync);
    assign w_mis[IDX_ASYNC] = (q_asyncrst_i !== w_exp_async);

    assign w_chk_next = (r_chk_cnt == '1) ? r_chk_cnt : r_chk_cnt + CNT_W'(1);
    assign w_err_next = (r_err_cnt == '1) ? r_err_cnt : r_err_cnt + CNT_W'(1);
    assign w_halt_hit = (w_err_next >= CNT_W'(MAX_ERR)) || (w_err_next == '1);

    // sequencing FSM with counters and first-error capture
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_err_flag  <= 1'b0;
            r_first_vec <= '0;
            r_first_cyc <= '0;
            r_chk_cnt   <= '0;
            r_err_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (en_i) begin
                        r_state     <= WARM;
                        r_err_flag  <= 1'b0;
                        r_first_vec <= '0;
                        r_first_cyc <= '0;
                        r_chk_cnt   <= '0;
                        r_err_cnt   <= '0;
                    end
                end
                WARM: begin
                    r_state <= en_i ? CHECK : IDLE;
                end
                CHECK: begin
                    if (!en_i) begin
                        r_state <= IDLE;
                    end else begin
                        r_chk_cnt <= w_chk_next;
                        if (|w_mis) begin
                            r_err_cnt  <= w_err_next;
                            r_err_flag <= 1'b1;
                            if (!r_err_flag) begin
                                r_first_vec <= w_mis;
                                r_first_cyc <= r_chk_cnt;
                            end
                            if (w_halt_hit) begin
                                r_state <= HALT;
                            end
                        end
                    end
                end
                HALT: begin
                    if (!en_i) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign err_o             = r_err_flag;
    assign first_err_vec_o   = r_first_vec;
    assign first_err_cycle_o = r_first_cyc;
    assign chk_cnt_o         = r_chk_cnt;
    assign err_cnt_o         = r_err_cnt;
    assign halted_o          = (r_state == HALT);

endmodule

// File: tb/tb_dff_resp_checker.sv
// Bench for dff_resp_checker: behavioural flops produce correct responses,
// a fault mask corrupts them on demand, and a spec-level scoreboard predicts
// the checker outputs.
module tb_dff_resp_checker;

    localparam int CNT_W   = 16;
    localparam int MAX_ERR = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             en_i = 1'b0;
    logic             dut_rst = 1'b0;
    logic             d = 1'b0;
    logic [2:0]       fault = 3'b000;
    logic             g_norst = 1'b0;
    logic             g_sync  = 1'b0;
    logic             g_async = 1'b0;
    logic             q_norst, q_sync, q_async;
    logic             err_o, halted_o;
    logic [2:0]       first_err_vec_o;
    logic [CNT_W-1:0] first_err_cycle_o, chk_cnt_o, err_cnt_o;

    int n_checks = 0;
    int n_errors = 0;

    // scoreboard state: phase 0=idle 1=warm 2=check 3=halt
    int         m_phase = 0;
    int         m_chk = 0, m_err = 0, m_cyc = 0;
    logic       m_flag = 1'b0;
    logic [2:0] m_vec = 3'b000;
    logic       m_dprev = 1'b0, m_rprev = 1'b0;
    localparam int SAT = (1 << CNT_W) - 1;

    always #5 clk = ~clk;

    always @(posedge clk) g_norst <= d;
    always @(posedge clk) g_sync <= dut_rst ? 1'b0 : d;
    always @(posedge clk or posedge dut_rst)
        if (dut_rst) g_async <= 1'b0;
        else         g_async <= d;

    assign q_norst = g_norst ^ fault[0];
    assign q_sync  = g_sync  ^ fault[1];
    assign q_async = g_async ^ fault[2];

    dff_resp_checker #(.WIDTH(1), .CNT_W(CNT_W), .MAX_ERR(MAX_ERR)) dut (
        .clk               (clk),
        .rst               (rst),
        .en_i              (en_i),
        .dut_rst_i         (dut_rst),
        .d_i               (d),
        .q_norst_i         (q_norst),
        .q_syncrst_i       (q_sync),
        .q_asyncrst_i      (q_async),
        .err_o             (err_o),
        .first_err_vec_o   (first_err_vec_o),
        .first_err_cycle_o (first_err_cycle_o),
        .chk_cnt_o         (chk_cnt_o),
        .err_cnt_o         (err_cnt_o),
        .halted_o          (halted_o)
    );

    task automatic model_edge(input logic en, input logic rn, input logic dr, input logic dd,
                              input logic qn, input logic qs, input logic qa);
        logic       en_exp, es_exp, ea_exp;
        logic [2:0] mis;
        en_exp = m_dprev;
        es_exp = m_rprev ? 1'b0 : m_dprev;
        ea_exp = (dr | m_rprev) ? 1'b0 : m_dprev;
        mis = {qa !== ea_exp, qs !== es_exp, qn !== en_exp};
        if (!rn) begin
            m_phase = 0; m_chk = 0; m_err = 0; m_cyc = 0; m_flag = 0; m_vec = 0;
            m_dprev = 0; m_rprev = 0;
        end else begin
            if (m_phase == 0) begin
                if (en) begin
                    m_phase = 1; m_chk = 0; m_err = 0; m_cyc = 0; m_flag = 0; m_vec = 0;
                end
            end else if (m_phase == 1) begin
                m_phase = en ? 2 : 0;
            end else if (m_phase == 2) begin
                if (!en) m_phase = 0;
                else begin
                    if (mis != 0) begin
                        if (!m_flag) begin m_vec = mis; m_cyc = m_chk; end
                        m_flag = 1;
                        if (m_err < SAT) m_err++;
                        if (m_err >= MAX_ERR || m_err == SAT) m_phase = 3;
                    end
                    if (m_chk < SAT) m_chk++;
                end
            end else begin
                if (!en) m_phase = 0;
            end
            m_dprev = dd;
            m_rprev = dr;
        end
    endtask

    task automatic step(input logic en, input logic rn, input logic dr, input logic dd,
                        input logic [2:0] fm);
        logic sn, ss, sa;
        @(negedge clk);
        en_i = en; rst = rn; dut_rst = dr; d = dd; fault = fm;
        #1;
        sn = q_norst; ss = q_sync; sa = q_async;
        @(posedge clk);
        model_edge(en, rn, dr, dd, sn, ss, sa);
        #1;
    endtask

    task automatic test_reset();
        step(0, 0, 0, 0, 3'b000);
        step(1, 0, 0, 1, 3'b000);
        n_checks++;
        if (err_o !== 1'b0) begin n_errors++; $display("FAIL reset_err got %0b want 0", err_o); end
        n_checks++;
        if (chk_cnt_o !== '0) begin n_errors++; $display("FAIL reset_chk got %0d want 0", chk_cnt_o); end
        n_checks++;
        if (err_cnt_o !== '0) begin n_errors++; $display("FAIL reset_errcnt got %0d want 0", err_cnt_o); end
        n_checks++;
        if ({halted_o, first_err_vec_o, first_err_cycle_o} !== '0) begin
            n_errors++; $display("FAIL reset_misc got %0b/%0b/%0d want 0", halted_o, first_err_vec_o, first_err_cycle_o);
        end
    endtask

    task automatic test_clean();
        logic [4:0] pat;
        pat = 5'b01101;
        for (int i = 0; i < 5; i++) step(1, 1, 0, pat[i], 3'b000);
        n_checks++;
        if (err_o !== 1'b0) begin n_errors++; $display("FAIL clean_err got %0b want 0", err_o); end
        n_checks++;
        if (chk_cnt_o !== CNT_W'(m_chk)) begin n_errors++; $display("FAIL clean_chk got %0d want %0d", chk_cnt_o, m_chk); end
    endtask

    task automatic test_sync_async();
        step(1, 1, 0, 1, 3'b000);
        step(1, 1, 1, 1, 3'b000);
        step(1, 1, 0, 1, 3'b000);
        step(1, 1, 0, 1, 3'b000);
        n_checks++;
        if (err_o !== 1'b0 || err_cnt_o !== '0) begin
            n_errors++; $display("FAIL sync_async got err=%0b cnt=%0d want 0/0", err_o, err_cnt_o);
        end
        n_checks++;
        if (chk_cnt_o !== CNT_W'(m_chk)) begin n_errors++; $display("FAIL sync_async_chk got %0d want %0d", chk_cnt_o, m_chk); end
    endtask

    task automatic test_fault();
        step(0, 1, 0, 1, 3'b000);
        step(1, 1, 0, 1, 3'b000);
        step(1, 1, 0, 1, 3'b000);
        step(1, 1, 1, 1, 3'b000);
        step(1, 1, 0, 1, 3'b010);
        n_checks++;
        if (err_o !== 1'b1) begin n_errors++; $display("FAIL fault_err got %0b want 1", err_o); end
        n_checks++;
        if (first_err_vec_o !== 3'b010) begin n_errors++; $display("FAIL fault_vec got %b want 010", first_err_vec_o); end
        n_checks++;
        if (err_cnt_o !== CNT_W'(1)) begin n_errors++; $display("FAIL fault_errcnt got %0d want 1", err_cnt_o); end
        n_checks++;
        if (first_err_cycle_o !== CNT_W'(m_cyc)) begin n_errors++; $display("FAIL fault_cycle got %0d want %0d", first_err_cycle_o, m_cyc); end
    endtask

    task automatic test_halt();
        step(0, 1, 0, 0, 3'b000);
        step(1, 1, 0, 0, 3'b000);
        step(1, 1, 0, 0, 3'b000);
        for (int i = 0; i < 8; i++) step(1, 1, 0, 1'($urandom_range(0, 1)), 3'b001);
        n_checks++;
        if (halted_o !== 1'b1) begin n_errors++; $display("FAIL halt_flag got %0b want 1", halted_o); end
        n_checks++;
        if (err_cnt_o !== CNT_W'(MAX_ERR)) begin n_errors++; $display("FAIL halt_errcnt got %0d want %0d", err_cnt_o, MAX_ERR); end
        n_checks++;
        if (chk_cnt_o !== CNT_W'(m_chk) || first_err_vec_o !== 3'b001) begin
            n_errors++; $display("FAIL halt_frozen got chk=%0d vec=%b want %0d/001", chk_cnt_o, first_err_vec_o, m_chk);
        end
        step(0, 1, 0, 0, 3'b001);
        n_checks++;
        if (halted_o !== 1'b0 || err_cnt_o !== CNT_W'(MAX_ERR)) begin
            n_errors++; $display("FAIL halt_idle got halted=%0b cnt=%0d want 0/%0d", halted_o, err_cnt_o, MAX_ERR);
        end
    endtask

    task automatic test_rearm();
        step(1, 1, 0, 1, 3'b000);
        n_checks++;
        if ({err_o, err_cnt_o, chk_cnt_o, first_err_vec_o} !== '0) begin
            n_errors++; $display("FAIL rearm_clear got err=%0b cnt=%0d chk=%0d vec=%b want all 0", err_o, err_cnt_o, chk_cnt_o, first_err_vec_o);
        end
        step(1, 1, 0, 0, 3'b000);
        n_checks++;
        if (chk_cnt_o !== '0) begin n_errors++; $display("FAIL rearm_warm got %0d want 0", chk_cnt_o); end
        step(1, 1, 0, 1, 3'b000);
        n_checks++;
        if (chk_cnt_o !== CNT_W'(1)) begin n_errors++; $display("FAIL rearm_first got %0d want 1", chk_cnt_o); end
    endtask

    task automatic test_reset_mid();
        step(1, 1, 0, 1, 3'b100);
        step(1, 1, 0, 0, 3'b000);
        step(1, 0, 0, 1, 3'b000);
        n_checks++;
        if ({err_o, err_cnt_o, chk_cnt_o, first_err_vec_o, first_err_cycle_o, halted_o} !== '0) begin
            n_errors++; $display("FAIL midrst_clear got err=%0b cnt=%0d chk=%0d want all 0", err_o, err_cnt_o, chk_cnt_o);
        end
        step(1, 1, 0, 1, 3'b000);
        step(1, 1, 0, 1, 3'b000);
        n_checks++;
        if (chk_cnt_o !== '0) begin n_errors++; $display("FAIL midrst_warm got %0d want 0", chk_cnt_o); end
        step(1, 1, 0, 1, 3'b000);
        n_checks++;
        if (chk_cnt_o !== CNT_W'(1)) begin n_errors++; $display("FAIL midrst_check got %0d want 1", chk_cnt_o); end
    endtask

    task automatic test_random();
        logic       en, rn, dr, dd;
        logic [2:0] fm;
        logic [3*CNT_W+4:0] got, want;
        for (int i = 0; i < 400; i++) begin
            en = ($urandom_range(0, 19) != 0);
            rn = ($urandom_range(0, 59) != 0);
            dr = ($urandom_range(0, 3) == 0);
            dd = 1'($urandom_range(0, 1));
            fm = ($urandom_range(0, 11) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            step(en, rn, dr, dd, fm);
            got  = {err_o, first_err_vec_o, first_err_cycle_o, chk_cnt_o, err_cnt_o, halted_o};
            want = {m_flag, m_vec, CNT_W'(m_cyc), CNT_W'(m_chk), CNT_W'(m_err), (m_phase == 3)};
            n_checks++;
            if (got !== want) begin
                n_errors++;
                $display("FAIL random_%0d got err=%0b vec=%b cyc=%0d chk=%0d cnt=%0d halt=%0b want %0b/%b/%0d/%0d/%0d/%0b",
                         i, err_o, first_err_vec_o, first_err_cycle_o, chk_cnt_o, err_cnt_o, halted_o,
                         m_flag, m_vec, m_cyc, m_chk, m_err, (m_phase == 3));
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_clean();
        test_sync_async();
        test_fault();
        test_halt();
        test_rearm();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
